// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence sqrt arbiter: widths, request tag, and
// one step of the non-restoring integer square root.
package geofence_pkg;

    localparam int SQRT_IN_W   = 32;
    localparam int SQRT_OUT_W  = 16;
    localparam int SQRT_REM_W  = 18;
    localparam int GF_NREQ_MAX = 8;
    localparam int GF_ID_W     = $clog2(GF_NREQ_MAX);

    typedef struct packed {
        logic               valid;
        logic [GF_ID_W-1:0] id;
    } gf_tag_t;

    typedef struct packed {
        logic [SQRT_REM_W-1:0] rem;
        logic [SQRT_OUT_W-1:0] root;
        logic [SQRT_IN_W-1:0]  rad;
    } sqrt_state_t;

    // One non-restoring iteration: consume the top two radical bits, add or subtract the
    // trial term depending on the remainder sign, and append one root bit.
    function automatic sqrt_state_t sqrt_step(input sqrt_state_t s);
        sqrt_state_t           n;
        logic [SQRT_REM_W-1:0] sh;
        sh = {s.rem[SQRT_REM_W-3:0], s.rad[SQRT_IN_W-1 -: 2]};
        if (!s.rem[SQRT_REM_W-1]) begin
            n.rem = sh - {s.root, 2'b01};
        end else begin
            n.rem = sh + {s.root, 2'b11};
        end
        n.root = {s.root[SQRT_OUT_W-2:0], ~n.rem[SQRT_REM_W-1]};
        n.rad  = {s.rad[SQRT_IN_W-3:0], 2'b00};
        return n;
    endfunction

endpackage

// File: rtl/geofence_isqrt_pipe.sv
// Pipelined 32-bit integer square root (16 iterations spread over SQRT_LAT register stages)
// with a side-band request tag shifted alongside the data.
module geofence_isqrt_pipe
    import geofence_pkg::*;
#(
    parameter int SQRT_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [SQRT_IN_W-1:0]  in_radical,
    input  gf_tag_t               in_tag,
    output logic [SQRT_OUT_W-1:0] out_root,
    output gf_tag_t               out_tag,
    output logic                  any_valid
);

    localparam int ITER = 16 / SQRT_LAT;

    logic [SQRT_LAT-1:0] valid_vec;

    for (genvar s = 0; s < SQRT_LAT; s++) begin : g_stage
        sqrt_state_t st_in;
        sqrt_state_t st_out;
        sqrt_state_t data_q;
        gf_tag_t     tag_in;
        gf_tag_t     tag_q;

        if (s == 0) begin : g_first
            assign st_in  = '{rem: '0, root: '0, rad: in_radical};
            assign tag_in = in_tag;
        end else begin : g_next
            assign st_in  = g_stage[s-1].data_q;
            assign tag_in = g_stage[s-1].tag_q;
        end

        always_comb begin
            st_out = st_in;
            for (int k = 0; k < ITER; k++) begin
                st_out = sqrt_step(st_out);
            end
        end

        // Only the tag valids are cleared by clr; the data just keeps flowing.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                tag_q  <= '0;
            end else begin
                data_q <= st_out;
                tag_q  <= clr ? gf_tag_t'('0) : tag_in;
            end
        end

        assign valid_vec[s] = tag_q.valid;
    end

    assign out_root  = g_stage[SQRT_LAT-1].data_q.root;
    assign out_tag   = g_stage[SQRT_LAT-1].tag_q;
    assign any_valid = |valid_vec;

endmodule

// File: rtl/geofence_sqrt_arbiter.sv
// Shares one pipelined sqrt unit among NREQ requesters with round-robin arbitration;
// define GEOFENCE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module geofence_sqrt_arbiter
    import geofence_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int SQRT_LAT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [SQRT_IN_W*NREQ-1:0] req_radical,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [SQRT_OUT_W-1:0]     resp_root,
    output logic                      busy
);

    logic [GF_ID_W-1:0]    win;
    logic                  found;
    logic                  grant;
    gf_tag_t               pipe_tag_in;
    gf_tag_t               pipe_tag_out;
    logic [SQRT_OUT_W-1:0] pipe_root;
    logic [SQRT_OUT_W-1:0] root_q;
    logic                  resp_fire;

`ifdef GEOFENCE_ARB_FIXED_PRIO_EN
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = GF_ID_W'(i);
            end
        end
    end
`else
    logic [GF_ID_W-1:0] rr_q;
    logic [GF_ID_W-1:0] rr_d;

    // Scan offsets high to low so the smallest offset from rr_q is the last (winning) write.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = GF_ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`endif

    assign grant = found && !flush && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant && (int'(win) == i);
        end
    end

    assign pipe_tag_in = '{valid: grant, id: win};

    geofence_isqrt_pipe #(
        .SQRT_LAT (SQRT_LAT)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .clr        (flush),
        .in_radical (req_radical[int'(win)*SQRT_IN_W +: SQRT_IN_W]),
        .in_tag     (pipe_tag_in),
        .out_root   (pipe_root),
        .out_tag    (pipe_tag_out),
        .any_valid  (busy)
    );

    // A response emerging during the flush cycle is suppressed as well.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = pipe_tag_out.valid && !flush && (int'(pipe_tag_out.id) == i);
        end
    end

    assign resp_fire = |resp_valid;
    assign resp_root = resp_fire ? pipe_root : root_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          root_q <= '0;
        else if (resp_fire) root_q <= pipe_root;
    end

endmodule
